mem_read_checker: RTL

Upstream driver and checker for the 256x16 test memory. Walks every address, drives addr/cs/byte_sel, and captures the low and high bytes from the 8-bit shared data bus. Compares each reassembled word against the expected init pattern and keeps pass/fail statistics. Each mismatch is streamed as a 3-byte record over a valid/ready byte interface to the downstream UART transmitter.

---
 rtl/mem_test_pkg.sv | 27 ++
 rtl/err_record_tx.sv | 74 +++++++
 rtl/mem_read_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_test_pkg.sv
// Shared definitions for the 256x16 test-memory read checker.
// Holds the default geometry and pattern, the checker FSM state encoding,
// the error-record length and the expected-word helper.
package mem_test_pkg;

  localparam int unsigned ADDR_W_DEFAULT       = 8;
  localparam logic [15:0] PATTERN_BASE_DEFAULT = 16'h000A;
  localparam int unsigned ERR_W_DEFAULT        = 9;
  localparam int unsigned REC_BYTES            = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RD_LO = 3'd2,
    RD_HI = 3'd3,
    CHECK = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Word the memory is expected to hold at addr; wraps modulo 2^16.
  function automatic logic [15:0] expected_word(input logic [15:0] base,
                                                input logic [15:0] addr);
    return base + addr;
  endfunction

endpackage

// File: rtl/err_record_tx.sv
// Error-record serializer: loaded with three bytes in one cycle, then
// presents them in order on a valid/ready byte interface.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   load            - capture byte0..byte2 and start presenting byte0
//   byte0..2_in     - record bytes, sent in that order
//   out_data        - current record byte (registered)
//   out_valid       - out_data is valid (registered)
//   out_ready       - downstream accepts the byte
//   last_accepted   - one-cycle pulse: the final byte is handshaking now
module err_record_tx
  import mem_test_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte0_in,
  input  logic [7:0] byte1_in,
  input  logic [7:0] byte2_in,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       last_accepted
);

  localparam logic [1:0] LAST_IDX = 2'(REC_BYTES - 1);

  // rec_q[23:16] is the byte currently on the bus; the rest shift up.
  logic [23:0] rec_q, rec_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        fire_s;

  // Next-state for the shift buffer, byte index and valid flag.
  always_comb begin
    rec_d         = rec_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    fire_s        = valid_q && out_ready;
    last_accepted = fire_s && (idx_q == LAST_IDX);
    if (load) begin
      rec_d   = {byte0_in, byte1_in, byte2_in};
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (fire_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = 2'd0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
        rec_d = {rec_q[15:0], 8'h00};
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Serializer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q   <= 24'h000000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      rec_q   <= rec_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = rec_q[23:16];
  assign out_valid = valid_q;

endmodule

// File: rtl/mem_read_checker.sv
// Walks every address of the test memory, reads each word as two bytes
// over the shared 8-bit bus, compares it with PATTERN_BASE + address and
// keeps pass/fail statistics. Every mismatching word is streamed out as a
// 3-byte record {addr, lo, hi} through err_record_tx.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - one-cycle pulse, honoured in IDLE/DONE only
//   mem_addr/mem_cs/mem_byte_sel - memory address, chip select, byte select
//   mem_data                   - byte bus from the memory
//   out_data/out_valid/out_ready - error-record byte stream
//   busy, done, pass           - run status (pass valid while done=1)
//   err_count, first_err_addr  - statistics of the last run
module mem_read_checker
  import mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [15:0] PATTERN_BASE = PATTERN_BASE_DEFAULT,
  parameter int unsigned ERR_W        = ERR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_byte_sel,
  input  logic [7:0]        mem_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               bsel_q, bsel_d;
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         hi_q, hi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic               word_eq_s;
  logic               addr_max_s;
  logic               load_s;
  logic               tx_last_s;

  // Written as a positive equality so an X/Z sample falls into the
  // mismatch branch of the FSM rather than the match branch.
  assign word_eq_s  = ({hi_q, lo_q} == expected_word(PATTERN_BASE, 16'(addr_q)));
  assign addr_max_s = &addr_q;

  // Checker FSM: next state, address walk and statistics.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ADDR;
          addr_d  = {ADDR_W{1'b0}};
          err_d   = {ERR_W{1'b0}};
          first_d = {ADDR_W{1'b0}};
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ADDR:  state_d = RD_LO;
      RD_LO: begin
        lo_d    = mem_data;
        state_d = RD_HI;
      end
      RD_HI: begin
        hi_d    = mem_data;
        state_d = CHECK;
      end
      CHECK: begin
        if (word_eq_s) begin
          if (addr_max_s) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == {ERR_W{1'b0}});
          end else begin
            state_d = ADDR;
            addr_d  = addr_q + ADDR_W'(1'b1);
          end
        end else begin
          err_d   = err_q + ERR_W'(1'b1);
          load_s  = 1'b1;
          state_d = EMIT;
          if (err_q == {ERR_W{1'b0}}) begin
            first_d = addr_q;
          end else begin
            first_d = first_q;
          end
        end
      end
      EMIT: begin
        // The address stays put until the whole record has been accepted.
        if (tx_last_s) begin
          if (addr_max_s) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == {ERR_W{1'b0}});
          end else begin
            state_d = ADDR;
            addr_d  = addr_q + ADDR_W'(1'b1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Memory strobes follow the state being entered so they are registered.
    cs_d   = (state_d == ADDR) || (state_d == RD_LO) || (state_d == RD_HI);
    bsel_d = (state_d == RD_HI);
  end

  // Checker state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      cs_q    <= 1'b0;
      bsel_q  <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= {ERR_W{1'b0}};
      first_q <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      bsel_q  <= bsel_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  err_record_tx u_tx (
    .clk           (clk),
    .reset         (reset),
    .load          (load_s),
    .byte0_in      (8'(addr_q)),
    .byte1_in      (lo_q),
    .byte2_in      (hi_q),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .last_accepted (tx_last_s)
  );

  assign mem_addr       = addr_q;
  assign mem_cs         = cs_q;
  assign mem_byte_sel   = bsel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
